// File: rtl/hdmi_tile_packer.sv
// Packs 24-bit FWFT FIFO pixels 4:3 into 32-bit stream words; 1 clk pop-to-tvalid, pops stall while the output word is held.
// Optional stats (tile/stall counters on tile_count) under HDMI_TILE_PACKER_STATS_EN.
module hdmi_tile_packer #(
  parameter int TILE_W = 64,
  parameter int TILE_H = 64,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] tile_count
);

  localparam int TILE_PIX = TILE_W * TILE_H;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TILE_PIX - 1);

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_e;

  phase_e           phase_q, phase_d;
  logic [23:0]      residue_q, residue_d;
  logic [CNT_W-1:0] pix_cnt_q;
  logic [31:0]      word_d;
  logic [31:0]      m_tdata_q;
  logic             m_tvalid_q, m_tlast_q, m_tuser_q;
  logic             out_free, pop, tile_done;

  assign out_free  = !m_tvalid_q || m_tready;
  // P0 only fills the residue, so it never needs room in the output register.
  assign pop       = reset_n && !flush && !fifo_empty && ((phase_q == P0) || out_free);
  assign tile_done = pop && (phase_q == P3) && (pix_cnt_q == LAST_PIX);

  assign fifo_rd_en = pop;
  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign m_tuser    = m_tuser_q;

  always_comb begin
    word_d    = '0;
    residue_d = residue_q;
    phase_d   = phase_q;
    unique case (phase_q)
      P0: begin
        residue_d = fifo_dout;
        phase_d   = P1;
      end
      P1: begin
        word_d    = {fifo_dout[7:0], residue_q};
        residue_d = {8'h00, fifo_dout[23:8]};
        phase_d   = P2;
      end
      P2: begin
        word_d    = {fifo_dout[15:0], residue_q[15:0]};
        residue_d = {16'h0000, fifo_dout[23:16]};
        phase_d   = P3;
      end
      P3: begin
        word_d    = {fifo_dout, residue_q[7:0]};
        phase_d   = P0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= P0;
      residue_q  <= '0;
      pix_cnt_q  <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
    end else begin
      if (flush) begin
        phase_q   <= P0;
        residue_q <= '0;
        pix_cnt_q <= '0;
      end else if (pop) begin
        phase_q   <= phase_d;
        residue_q <= residue_d;
        pix_cnt_q <= tile_done ? '0 : pix_cnt_q + CNT_W'(1);
      end
      // A word already in the output register survives flush and drains normally.
      if (pop && (phase_q != P0)) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= word_d;
        m_tuser_q  <= (phase_q == P1) && (pix_cnt_q == CNT_W'(1));
        m_tlast_q  <= tile_done;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

`ifdef HDMI_TILE_PACKER_STATS_EN
  logic [15:0] tile_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (tile_done)
        tile_cnt_q <= tile_cnt_q + 16'd1;
      if (m_tvalid_q && !m_tready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Holding flush doubles as the debug strobe for the stall counter.
  assign tile_count = flush ? stall_cnt_q : tile_cnt_q;
`else
  assign tile_count = '0;
`endif

endmodule

// File: doc/hdmi_tile_packer.md
Name: hdmi_tile_packer

Overview:
- Consumes the 24-bit {red,green,blue} pixels that the HDMI capture stage writes into the pixel FIFO.
- Packs every 4 pixels (96 bits) into 3 32-bit words with no padding.
- Presents the words as a 32-bit AXI-Stream-style master toward the transport/DMA path.
- Marks the first word of each tile (tuser) and the last word of each tile (tlast).

Parameters:
- TILE_W, 64, pixels per tile row.
- TILE_H, 64, rows per tile. TILE_W*TILE_H must be a multiple of 4.
- CNT_W, 16, width of the pixel counter. Must satisfy 2^CNT_W >= TILE_W*TILE_H.

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops partial state and restarts the tile.
- fifo_empty  in  1  pixel FIFO empty flag (FWFT FIFO).
- fifo_dout  in  24  FWFT head data {red[23:16],green[15:8],blue[7:0]}; valid when !fifo_empty.
- fifo_rd_en  out  1  pop strobe; combinational.
- m_tdata  out  32  packed word.
- m_tvalid  out  1  word valid.
- m_tready  in  1  downstream accept.
- m_tlast  out  1  last word of tile.
- m_tuser  out  1  first word of tile.
- tile_count  out  16  completed tiles (see optional feature).

Behaviour:
- Reset (async, reset_n=0): m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, phase=0, residue=0, pix_cnt=0, tile_count=0. fifo_rd_en=0 while in reset.
- Output register free: out_free = !m_tvalid | m_tready.
- Phase FSM P0..P3 (2-bit phase, residue register up to 24 bits):
  - P0: fifo_rd_en = !fifo_empty. On pop: residue<=fifo_dout; no word produced; ->P1.
  - P1: fifo_rd_en = !fifo_empty & out_free. On pop: m_tdata<={dout[7:0],residue[23:0]}; residue<=dout[23:8]; ->P2.
  - P2: fifo_rd_en = !fifo_empty & out_free. On pop: m_tdata<={dout[15:0],residue[15:0]}; residue<=dout[23:16]; ->P3.
  - P3: fifo_rd_en = !fifo_empty & out_free. On pop: m_tdata<={dout[23:0],residue[7:0]}; ->P0.
- Word production:
  - A pop in P1–P3 loads the output register and sets m_tvalid=1 on the next edge (latency 1 clk from pop).
  - If m_tready with no new word, m_tvalid<=0.
  - m_tdata/m_tlast/m_tuser are held stable while m_tvalid & !m_tready.
- Throughput: sustains 1 pixel/clk when m_tready=1 (3 words per 4 clks).
- pix_cnt increments on every pop.
  - m_tuser=1 on the word produced in P1 when pix_cnt==1 (first word of tile).
  - m_tlast=1 on the word produced in P3 when pix_cnt==TILE_W*TILE_H-1. That pop wraps pix_cnt to 0 and increments tile_count (wraps at 0xFFFF).
- fifo_empty=1 in any phase: no pop, state held; tvalid may still drain.
- flush=1: phase<=P0, residue<=0, pix_cnt<=0, fifo_rd_en forced 0 that cycle.
  - A word already valid in the output register is NOT dropped; it completes its handshake.
  - tile_count is not affected.
- flush and pop in the same cycle: flush wins; no pop occurs.
- reset_n asserted mid-tile: all state cleared immediately; the partial tile is lost.

Optional Feature:
- Macro HDMI_TILE_PACKER_STATS_EN.
- Defined: tile_count operates as described. A 16-bit stall counter also increments each clk with m_tvalid & !m_tready, saturating at 0xFFFF. It is exposed on tile_count when flush is held high (debug readout); otherwise tile_count is shown.
- Undefined: tile_count is tied to 0 and no counters are synthesized.

Test Plan:
- Push pixels 0x010203, 0x040506, 0x070809, 0x0A0B0C with m_tready=1 -> words 0x06010203, 0x08090405, 0x0A0B0C07; first word has m_tuser=1; 4 pops in 4 clks.
- Stream a full 4096-pixel tile with m_tready=1 -> exactly 3072 words; m_tlast only on word 3072; tile_count=1 (macro defined).
- Random m_tready (50%) with continuous FIFO -> no pop while output is stalled; tdata stable during stall; output matches the reference packing model bit-exactly.
- Pop 2 pixels, assert flush 1 clk, then push 0x010203, 0x040506, 0x070809, 0x0A0B0C -> output words identical to scenario 1 with m_tuser=1; no stale residue.
- Assert reset_n=0 asynchronously mid-tile with m_tvalid=1 -> m_tvalid drops to 0 without a clock edge; the next tile starts clean at P0.
- Macro defined, hold m_tready=0 for 10 clks with m_tvalid=1 -> stall counter reads 10 while flush=1.
